// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state and the
// bundle of stage-register enables and flushes.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [0:0] {
    RUN         = 1'b0,
    MULDIV_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctrl_t;

  // Free-running pipe: every register advances, nothing is squashed.
  function automatic pipe_ctrl_t ctrl_run();
    pipe_ctrl_t c;
    c = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
          mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
          ex_mem_flush: 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_cnt.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module pipe_hazard_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipe: load-use, taken branch
// and mul/div freeze. Define HAZARD_STATS_EN to add stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W    = REG_ADDR_W_DEF,
  parameter int MULDIV_CYCLES = 8,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  branch_taken_ex,
  input  logic                  muldiv_start_ex,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  muldiv_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);

  localparam int CW = $clog2(MULDIV_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          load_use;
  pipe_ctrl_t    ctrl;

  // Register 0 is hardwired zero, so a load targeting it can never feed ID.
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    ctrl        = ctrl_run();
    muldiv_busy = 1'b0;
    state_n     = state;
    cnt_n       = cnt;
    if (reset) begin
      ctrl = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
               mem_wb_en: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1,
               ex_mem_flush: 1'b1};
    end else begin
      case (state)
        RUN: begin
          if (branch_taken_ex) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (muldiv_start_ex) begin
            state_n = MULDIV_BUSY;
            cnt_n   = CNT_INIT;
          end else if (load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end
        end
        MULDIV_BUSY: begin
          // Front frozen; EX/MEM takes bubbles so older work drains out.
          ctrl.pc_en        = 1'b0;
          ctrl.if_id_en     = 1'b0;
          ctrl.id_ex_en     = 1'b0;
          ctrl.ex_mem_flush = 1'b1;
          muldiv_busy       = 1'b1;
          if (cnt == '0) begin
            state_n = RUN;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: begin
          state_n = RUN;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign id_ex_en     = ctrl.id_ex_en;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;

`ifdef HAZARD_STATS_EN
  logic stall_inc, flush_inc;

  assign stall_inc = !reset && !ctrl.pc_en;
  assign flush_inc = !reset && (state == RUN) && branch_taken_ex;

  pipe_hazard_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (stall_inc),
    .q   (stall_cycles)
  );

  pipe_hazard_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (flush_inc),
    .q   (flush_events)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: cycle-level reference model plus
// directed literal expectations and randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;
  localparam int MC = 8;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  // Output vector order: pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,ex_mem flush | busy
  localparam logic [8:0] V_RESET = 9'b00000_111_0;
  localparam logic [8:0] V_IDLE  = 9'b11111_000_0;
  localparam logic [8:0] V_LU    = 9'b00111_010_0;
  localparam logic [8:0] V_BR    = 9'b11111_110_0;
  localparam logic [8:0] V_BUSY  = 9'b00011_001_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [RW-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, branch_taken_ex, muldiv_start_ex;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_cycles, flush_events;
`endif

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .MULDIV_CYCLES(MC), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .branch_taken_ex (branch_taken_ex),
    .muldiv_start_ex (muldiv_start_ex),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .muldiv_busy     (muldiv_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
`endif
  );

  int checks = 0;
  int errors = 0;
  int busy_left = 0;  // freeze cycles still owed by the mul/div unit
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic [8:0] model_out();
    logic hit;
    if (reset) return V_RESET;
    if (busy_left > 0) return V_BUSY;
    if (branch_taken_ex) return V_BR;
    if (muldiv_start_ex) return V_IDLE;
    hit = ex_mem_read && (ex_rt != 0) &&
          ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    return hit ? V_LU : V_IDLE;
  endfunction

  task automatic set_in(input logic r, input int rs, input int rt, input logic u,
                        input logic mr, input int ert, input logic br, input logic md);
    reset           = r;
    id_rs           = RW'(rs);
    id_rt           = RW'(rt);
    id_uses_rt      = u;
    ex_mem_read     = mr;
    ex_rt           = RW'(ert);
    branch_taken_ex = br;
    muldiv_start_ex = md;
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic cyc(input logic [8:0] lit, input bit use_lit, input string name);
    logic [8:0] got, exp;
    #2;
    got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy};
    exp = model_out();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_%s t=%0t got=%b expected=%b", name, $time, got, exp);
    end
    if (use_lit) begin
      checks++;
      if (got !== lit) begin
        errors++;
        $display("FAIL lit_%s t=%0t got=%b expected=%b", name, $time, got, lit);
      end
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if ((stall_cycles !== CW'(m_stall)) || (flush_events !== CW'(m_flush))) begin
      errors++;
      $display("FAIL stats_%s t=%0t got=%0d/%0d expected=%0d/%0d", name, $time,
               stall_cycles, flush_events, m_stall, m_flush);
    end
`endif
    @(posedge clk);
    if (reset) begin
      busy_left = 0;
      m_stall   = 0;
      m_flush   = 0;
    end else begin
      if (!exp[8] && m_stall < SAT) m_stall++;
      if (busy_left == 0 && branch_taken_ex && m_flush < SAT) m_flush++;
      if (busy_left > 0) busy_left--;
      else if (!branch_taken_ex && muldiv_start_ex) busy_left = MC;
    end
    @(negedge clk);
  endtask

  task automatic idle_cyc(input bit use_lit, input string name);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(V_IDLE, use_lit, name);
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc(V_RESET, 1, "reset0");
    cyc(V_RESET, 1, "reset1");
    idle_cyc(1, "post_reset");

    set_in(0, 5, 0, 0, 1, 5, 0, 0);  cyc(V_LU, 1, "lu_rs");
    idle_cyc(1, "lu_rs_after");
    set_in(0, 0, 0, 0, 1, 0, 0, 0);  cyc(V_IDLE, 1, "lu_r0");
    set_in(0, 3, 7, 0, 1, 7, 0, 0);  cyc(V_IDLE, 1, "rt_unused");
    set_in(0, 3, 7, 1, 1, 7, 0, 0);  cyc(V_LU, 1, "rt_used");
    set_in(0, 5, 0, 0, 1, 5, 1, 0);  cyc(V_BR, 1, "br_over_lu");
    set_in(0, 5, 0, 0, 1, 5, 1, 1);  cyc(V_BR, 1, "br_over_md");
    idle_cyc(1, "br_after");

    set_in(0, 0, 0, 0, 0, 0, 0, 1);  cyc(V_IDLE, 1, "md_start");
    for (int i = 0; i < MC; i++) begin
      set_in(0, 5, 0, 0, 1, 5, (i == 2), (i == 4));
      cyc(V_BUSY, 1, "md_busy");
    end
    idle_cyc(1, "md_done");

    set_in(0, 0, 0, 0, 0, 0, 0, 1);  cyc(V_IDLE, 1, "md2_start");
    idle_cyc(0, "md2_b1");
    idle_cyc(0, "md2_b2");
    set_in(1, 0, 0, 0, 0, 0, 0, 0);  cyc(V_RESET, 1, "md2_reset");
    idle_cyc(1, "md2_after_reset");
    idle_cyc(1, "md2_after_reset2");

`ifdef HAZARD_STATS_EN
    for (int i = 0; i < 20; i++) begin
      set_in(0, 9, 0, 0, 1, 9, 0, 0);
      cyc(V_LU, 0, "stat_lu");
    end
    idle_cyc(0, "stat_lu_end");
    checks++;
    if (stall_cycles !== 4'd15) begin
      errors++;
      $display("FAIL stall_sat got=%0d expected=15", stall_cycles);
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0);  cyc(V_RESET, 0, "stat_reset");
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);  cyc(V_BR, 0, "stat_br");
      idle_cyc(0, "stat_br_gap");
    end
    checks++;
    if (flush_events !== 4'd3) begin
      errors++;
      $display("FAIL flush_cnt got=%0d expected=3", flush_events);
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 99) < 2), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 8));
      cyc(V_IDLE, 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
